uart_rx_edge_bit_sampler: RTL
=============================

Name: uart_rx_edge_bit_sampler

Overview:
Timing and sampling front-end of the UART receiver, directly upstream of the receive control FSM.
- Synchronises the serial RX line.
- Runs the oversampling edge counter and the frame bit counter that the FSM decodes.
- Produces a majority-voted data bit per bit period, consumed by the start/parity/stop checkers and the deserializer.

Parameters:
EDGE_W, 3, edge-counter width; maximum oversampling factor is 2^EDGE_W.
BIT_W, 4, bit-counter width; holds 0..10: start, 8 data, parity, stop.

Ports:
CLK  in  1  system clock of the RX domain.
RST  in  1  asynchronous active-low reset.
RXIn  in  1  raw serial line; idle high.
Prescale  in  EDGE_W+1  oversampling factor; legal values are powers of two from 8 to 2^EDGE_W.
CounterEnable  in  1  from FSM; high = count, low = clear both counters.
RXSync  out  1  synchronised line; drives FSM SData.
EdgeCounter  out  EDGE_W  oversample index within the current bit.
BitCounter  out  BIT_W  bit index within the frame.
SampledBit  out  1  majority-voted value of the current bit.
SampleValid  out  1  single-cycle pulse when SampledBit updates.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST. While RST=0, all flops clear; outputs then read:
  - RXSync=1 (sync flops preset high, the idle level)
  - EdgeCounter=0, BitCounter=0
  - SampledBit=1, SampleValid=0
- Effective prescale P:
  - P = Prescale when legal.
  - Any illegal value (non-power-of-two, <8, or >2^EDGE_W) is treated as 2^EDGE_W.
  - Last edge L = P-1; mid M = P/2.
- Counters (registered):
  - CounterEnable=0: next EdgeCounter=0 and BitCounter=0, regardless of current values.
  - CounterEnable=1 and EdgeCounter<L: EdgeCounter+1; BitCounter holds.
  - CounterEnable=1 and EdgeCounter==L: EdgeCounter wraps to 0; BitCounter+1 (modulo 2^BIT_W, no saturation).
  - The FSM decodes EdgeCounter==L combinationally; outputs are direct flop outputs with no extra latency.
- Sampler:
  - Captures RXSync into three sample flops at EdgeCounter = M-1, M and M+1 (while CounterEnable=1).
  - On the clock ending edge M+1, SampledBit <= majority(s0,s1,s2), computed with the live third sample. SampledBit is therefore visible from edge M+2, which is ≤ L-1 for P≥8, so it is stable when the FSM acts at edge L.
  - SampleValid=1 for exactly the cycle in which EdgeCounter==M+2.
  - SampledBit holds between updates.
- CounterEnable dropped mid-bit: no further SampleValid and no SampledBit update; counters clear on the next clock.
- A Prescale change while CounterEnable=1 is unsupported; behaviour is defined only after a CounterEnable=0 cycle.
- Reset mid-frame returns to the reset values immediately (asynchronous).

Optional Feature:
UART_RX_SYNC_EN
- Defined: RXSync is a 2-flop synchroniser on RXIn, preset to 1; latency 2 cycles.
- Undefined: RXSync = RXIn combinationally (for an RX line already synchronous to CLK); sampling points and counter behaviour unchanged.

Decomposition:
- Shared UART RX package holds:
  - EDGE_W and BIT_W defaults
  - bit-index constants: BIT_START=0, BIT_DATA_LAST=8, BIT_PARITY=9, BIT_STOP=10
  - the legal-prescale check function
- One natural sub-module, uart_rx_sync2: the 2-flop synchroniser instantiated under UART_RX_SYNC_EN.
- Counters and the majority voter stay inline.

Test Plan:
- Reset check: RST=0 with RXIn toggling -> RXSync=1, counters=0, SampledBit=1, SampleValid=0; release RST -> values hold until CounterEnable=1.
- Count sweep: Prescale=8, CounterEnable=1 for 88 cycles -> EdgeCounter cycles 0..7; BitCounter steps 0..10, incrementing on each clock after EdgeCounter=7; drop CounterEnable -> both read 0 next cycle.
- Majority vote: Prescale=8, RXSync held at 0 except a 1-cycle high at edge 4 -> SampledBit=0 with SampleValid pulse at edge 6. Pattern 1,0,1 at edges 3,4,5 -> SampledBit=1.
- Frame at Prescale=8: frame 0, 0xA5 LSB-first, parity 0, stop 1 -> SampledBit at each edge-7 strobe reads 0,1,0,1,0,0,1,0,1,0,1.
- Illegal prescale: Prescale=5 with EDGE_W=3 -> behaves as 8 (wrap at 7, samples at 3/4/5); Prescale=8 after CounterEnable=0 -> normal.
- Macro compare: same stimulus with and without UART_RX_SYNC_EN -> RXSync lags RXIn by 2 cycles when defined, 0 cycles when not; counter sequence is identical relative to CounterEnable.

Source files
------------

// File: rtl/uart_rx_edge_bit_sampler_pkg.sv
// Shared UART RX definitions: default counter widths, frame bit indices and
// the oversampling-factor legality check used by the edge counter.
package uart_rx_edge_bit_sampler_pkg;

  localparam int EDGE_W_DEFAULT = 3;
  localparam int BIT_W_DEFAULT  = 4;

  localparam int BIT_START     = 0;
  localparam int BIT_DATA_LAST = 8;
  localparam int BIT_PARITY    = 9;
  localparam int BIT_STOP      = 10;

  // Legal oversampling factors are powers of two from 8 up to 2^edgeW.
  function automatic logic prescaleLegal(input logic [31:0] prescale, input int edgeW);
    logic [31:0] maxPrescale;
    maxPrescale = 32'd1 << edgeW;
    return (prescale >= 32'd8) && (prescale <= maxPrescale) &&
           ((prescale & (prescale - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_sampler_if.sv
// Bundle between the RX receive-control FSM (master) and the edge/bit sampler
// (slave): line input, prescale, counter enable and the sampler's outputs.
interface uart_rx_edge_bit_sampler_if
  import uart_rx_edge_bit_sampler_pkg::*;
#(
  parameter int EDGE_W = EDGE_W_DEFAULT,
  parameter int BIT_W  = BIT_W_DEFAULT
);

  logic              RXIn;
  logic [EDGE_W:0]   Prescale;
  logic              CounterEnable;
  logic              RXSync;
  logic [EDGE_W-1:0] EdgeCounter;
  logic [BIT_W-1:0]  BitCounter;
  logic              SampledBit;
  logic              SampleValid;

  modport master (
    output RXIn, Prescale, CounterEnable,
    input  RXSync, EdgeCounter, BitCounter, SampledBit, SampleValid
  );

  modport slave (
    input  RXIn, Prescale, CounterEnable,
    output RXSync, EdgeCounter, BitCounter, SampledBit, SampleValid
  );

endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for the asynchronous RX line; both flops preset to the
// idle-high level so the receiver never sees a false start bit out of reset.
module uart_rx_sync2 (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      meta_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      meta_p0 <= D;
      sync_p1 <= meta_p0;
    end
  end

  assign Q = sync_p1;

endmodule

// File: rtl/uart_rx_edge_bit_sampler.sv
// UART RX timing front-end: line sync, oversample edge counter, frame bit
// counter and 3-point majority sampler. UART_RX_SYNC_EN adds the 2-flop sync.
module uart_rx_edge_bit_sampler
  import uart_rx_edge_bit_sampler_pkg::*;
#(
  parameter int EDGE_W = EDGE_W_DEFAULT,
  parameter int BIT_W  = BIT_W_DEFAULT
) (
  input logic CLK,
  input logic RST,
  uart_rx_edge_bit_sampler_if.slave bus
);

  logic rxSync;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync2 u_sync2 (
    .CLK (CLK),
    .RST (RST),
    .D   (bus.RXIn),
    .Q   (rxSync)
  );
`else
  assign rxSync = bus.RXIn;
`endif

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Sampling points derive from the effective prescale; illegal values fall
  // back to the widest factor so the counter still wraps at a sane point.
  logic              prescaleOk;
  logic [EDGE_W-1:0] lastEdge;
  logic [EDGE_W-1:0] midEdge;
  logic [EDGE_W-1:0] earlyEdge;
  logic [EDGE_W-1:0] voteEdge;

  always_comb begin
    prescaleOk = prescaleLegal(32'(bus.Prescale), EDGE_W);
    if (prescaleOk) begin
      lastEdge = EDGE_W'(bus.Prescale - (EDGE_W+1)'(1));
      midEdge  = EDGE_W'(bus.Prescale >> 1);
    end else begin
      lastEdge = '1;
      midEdge  = {1'b1, {(EDGE_W-1){1'b0}}};
    end
    earlyEdge = midEdge - EDGE_W'(1);
    voteEdge  = midEdge + EDGE_W'(1);
  end

  // Stage p0: oversample edge counter and frame bit counter
  logic [EDGE_W-1:0] edgeCnt_p0;
  logic [BIT_W-1:0]  bitCnt_p0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edgeCnt_p0 <= '0;
      bitCnt_p0  <= '0;
    end else if (!bus.CounterEnable) begin
      edgeCnt_p0 <= '0;
      bitCnt_p0  <= '0;
    end else if (edgeCnt_p0 == lastEdge) begin
      edgeCnt_p0 <= '0;
      bitCnt_p0  <= bitCnt_p0 + BIT_W'(1);
    end else begin
      edgeCnt_p0 <= edgeCnt_p0 + EDGE_W'(1);
    end
  end

  // Stage p1: mid-bit samples and vote; the third sample is taken live so the
  // voted bit lands one edge earlier and is settled well before the last edge.
  logic sampleEarly_p1;
  logic sampleMid_p1;
  logic sampledBit_p1;
  logic vld_p1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sampleEarly_p1 <= 1'b1;
      sampleMid_p1   <= 1'b1;
      sampledBit_p1  <= 1'b1;
      vld_p1         <= 1'b0;
    end else begin
      vld_p1 <= bus.CounterEnable && (edgeCnt_p0 == voteEdge);
      if (bus.CounterEnable && (edgeCnt_p0 == earlyEdge)) begin
        sampleEarly_p1 <= rxSync;
      end
      if (bus.CounterEnable && (edgeCnt_p0 == midEdge)) begin
        sampleMid_p1 <= rxSync;
      end
      if (bus.CounterEnable && (edgeCnt_p0 == voteEdge)) begin
        sampledBit_p1 <= majority3(sampleEarly_p1, sampleMid_p1, rxSync);
      end
    end
  end

  assign bus.RXSync      = rxSync;
  assign bus.EdgeCounter = edgeCnt_p0;
  assign bus.BitCounter  = bitCnt_p0;
  assign bus.SampledBit  = sampledBit_p1;
  assign bus.SampleValid = vld_p1;

endmodule
